// File: rtl/serial_sm2tc.sv
// rtl/serial_sm2tc.sv - bit-serial sign-magnitude to two's-complement converter
// Optional neg_zero output is enabled by defining SM2TC_NEGZERO_FLAG_EN.
`ifndef REG_SIZE
`define REG_SIZE 7
`endif

module serial_sm2tc (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [`REG_SIZE:0]   mag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`REG_SIZE+1:0] out_tc,
  output logic                 busy
`ifdef SM2TC_NEGZERO_FLAG_EN
  ,
  output logic                 neg_zero
`endif
);

  localparam int N  = `REG_SIZE + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [N-1:0]   sr;
  logic [N-1:0]   shifted;
  logic [CW-1:0]  cnt;
  logic           sign_q;
  logic           seen_one;
  logic           raw_bit;
  logic           tc_bit;
`ifdef SM2TC_NEGZERO_FLAG_EN
  logic           nz_q;
`endif

  // Negation copies bits through the first 1 and inverts every bit after it.
  assign raw_bit = sr[0];
  assign tc_bit  = (sign_q && seen_one) ? ~raw_bit : raw_bit;
  assign shifted = {tc_bit, sr[N-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // out_tc is a separate holding register so it only changes when a result completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      seen_one <= 1'b0;
      out_tc   <= '0;
`ifdef SM2TC_NEGZERO_FLAG_EN
      nz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= {1'b0, mag};
            sign_q   <= sign;
            seen_one <= 1'b0;
            cnt      <= CNT_LOAD;
`ifdef SM2TC_NEGZERO_FLAG_EN
            nz_q     <= sign && (mag == '0);
`endif
          end
        end
        SHIFT: begin
          sr       <= shifted;
          seen_one <= seen_one | raw_bit;
          if (cnt == '0) begin
            out_tc <= shifted;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SM2TC_NEGZERO_FLAG_EN
  assign neg_zero = nz_q;
`endif

endmodule

// File: tb/tb_serial_sm2tc.sv
// tb/tb_serial_sm2tc.sv - directed and random self-checking bench for serial_sm2tc
// Honours SM2TC_NEGZERO_FLAG_EN for the neg_zero port.
`ifndef REG_SIZE
`define REG_SIZE 7
`endif

module tb_serial_sm2tc;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic       sign;
  logic [7:0] mag;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_tc;
  logic       busy;
`ifdef SM2TC_NEGZERO_FLAG_EN
  logic       neg_zero;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_sm2tc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .mag       (mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tc    (out_tc),
    .busy      (busy)
`ifdef SM2TC_NEGZERO_FLAG_EN
    ,
    .neg_zero  (neg_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic convert(input logic s, input logic [7:0] m, output logic [8:0] tc,
                         output int edges, output int bcnt, output bit ok);
    sign = s;
    mag = m;
    in_valid = 1'b1;
    edges = 0;
    bcnt = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      in_valid = 1'b0;
      if (busy) bcnt++;
    end while (!out_valid && edges < 40);
    ok = out_valid;
    tc = out_tc;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; sign = 1'b0; mag = '0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, busy, out_tc} !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b tc=%h expected 1 0 0 000",
               in_ready, out_valid, busy, out_tc);
    end
`ifdef SM2TC_NEGZERO_FLAG_EN
    n_cmp++;
    if (neg_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_neg_zero: got %b expected 0", neg_zero);
    end
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_positive();
    logic [8:0] tc; int e, b; bit ok;
    convert(1'b0, 8'h2D, tc, e, b, ok);
    n_cmp++;
    if (e !== 10) begin n_fail++; $display("FAIL pos_latency: got %0d edges expected 10", e); end
    n_cmp++;
    if (b !== 9) begin n_fail++; $display("FAIL pos_busy_cycles: got %0d expected 9", b); end
    n_cmp++;
    if (tc !== 9'h02D) begin n_fail++; $display("FAIL pos_value: got %h expected 02d", tc); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready: got %b expected 0", in_ready); end
    release_result();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL pos_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_negative();
    logic [8:0] tc; int e, b; bit ok;
    convert(1'b1, 8'h2D, tc, e, b, ok);
    n_cmp++;
    if (tc !== 9'h1D3 || !ok) begin n_fail++; $display("FAIL neg_2d: got %h expected 1d3", tc); end
    release_result();
    convert(1'b1, 8'hFF, tc, e, b, ok);
    n_cmp++;
    if (tc !== 9'h101 || !ok) begin n_fail++; $display("FAIL neg_ff: got %h expected 101", tc); end
`ifdef SM2TC_NEGZERO_FLAG_EN
    n_cmp++;
    if (neg_zero !== 1'b0) begin n_fail++; $display("FAIL neg_zero_ff: got %b expected 0", neg_zero); end
`endif
    release_result();
    convert(1'b0, 8'hFF, tc, e, b, ok);
    n_cmp++;
    if (tc !== 9'h0FF || !ok) begin n_fail++; $display("FAIL pos_ff: got %h expected 0ff", tc); end
    release_result();
  endtask

  task automatic test_neg_zero();
    logic [8:0] tc; int e, b; bit ok;
    convert(1'b1, 8'h00, tc, e, b, ok);
    n_cmp++;
    if (tc !== 9'h000 || !ok) begin n_fail++; $display("FAIL neg_zero_value: got %h expected 000", tc); end
`ifdef SM2TC_NEGZERO_FLAG_EN
    n_cmp++;
    if (neg_zero !== 1'b1) begin n_fail++; $display("FAIL neg_zero_flag: got %b expected 1", neg_zero); end
`endif
    release_result();
  endtask

  task automatic test_backpressure();
    logic [8:0] tc; int e, b; bit ok;
    convert(1'b1, 8'h01, tc, e, b, ok);
    n_cmp++;
    if (tc !== 9'h1FF || !ok) begin n_fail++; $display("FAIL bp_value: got %h expected 1ff", tc); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      sign = 1'b0;
      mag = 8'h55;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, busy, out_tc} !== {1'b1, 1'b0, 1'b0, 9'h1FF}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b busy=%b tc=%h expected 1 0 0 1ff",
                 i, out_valid, in_ready, busy, out_tc);
      end
    end
    in_valid = 1'b1;
    release_result();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_exit_no_accept: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_tc !== 9'h1FF) begin n_fail++; $display("FAIL bp_tc_kept: got %h expected 1ff", out_tc); end
  endtask

  task automatic test_idle_out_ready();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy, out_tc} !== {1'b0, 1'b1, 1'b0, 9'h1FF}) begin
      n_fail++;
      $display("FAIL idle_out_ready: got vld=%b rdy=%b busy=%b tc=%h expected 0 1 0 1ff",
               out_valid, in_ready, busy, out_tc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [8:0] tc; int e, b; bit ok; bit saw_valid;
    sign = 1'b1; mag = 8'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, out_tc} !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got rdy=%b vld=%b busy=%b tc=%h expected 1 0 0 000",
               in_ready, out_valid, busy, out_tc);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: got activity=1 expected 0"); end
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    convert(1'b1, 8'h2D, tc, e, b, ok);
    n_cmp++;
    if ({tc, e[7:0], b[7:0]} !== {9'h1D3, 8'd10, 8'd9}) begin
      n_fail++;
      $display("FAIL post_reset_convert: got tc=%h edges=%0d busy=%0d expected 1d3 10 9", tc, e, b);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [8:0] tc; logic [8:0] exp_tc; int e, b; bit ok;
    logic s; logic [7:0] m;
    int ops, results, stall;
    ops = 0; results = 0;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      m = 8'($urandom);
      exp_tc = s ? 9'(-{1'b0, m}) : {1'b0, m};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      convert(s, m, tc, e, b, ok);
      ops++;
      if (ok) results++;
      n_cmp++;
      if (tc !== exp_tc || !ok) begin
        n_fail++;
        $display("FAIL rand[%0d] s=%b m=%h: got %h valid=%b expected %h", i, s, m, tc, ok, exp_tc);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
      end
      if (stall > 0) begin
        n_cmp++;
        if (out_tc !== exp_tc || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_stall[%0d]: got tc=%h vld=%b expected %h 1", i, out_tc, out_valid, exp_tc);
        end
      end
      release_result();
    end
    n_cmp++;
    if (results !== ops) begin n_fail++; $display("FAIL rand_count: got %0d results expected %0d", results, ops); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_neg_zero();
    test_backpressure();
    test_idle_out_ready();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sm2tc.md
SERIAL_SM2TC -- requirements
Module: serial_sm2tc

Interface
REQ-001 SHALL take its width from the global macro `REG_SIZE (no default; codebase-wide): magnitude width M = `REG_SIZE+1, output width N = `REG_SIZE+2.
REQ-002 SHALL have no module parameters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  sign/mag operand present.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 sign  input  1  operand sign (1 = negative), sign-magnitude format as produced by the Adder.
REQ-008 mag  input  [`REG_SIZE:0]  operand magnitude, unsigned.
REQ-009 out_valid  output  1  result held on out_tc.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_tc  output  [`REG_SIZE+1:0]  two's-complement result.
REQ-012 busy  output  1  high in SHIFT state.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 at an edge captures {1'b0,mag} into an N-bit shift register, latches sign, clears the seen-one flag, loads the bit counter with N-1, and moves to SHIFT.
REQ-015 SHIFT: each cycle shift one bit LSB-first; output bit = raw bit if sign=0, else raw bit XOR seen_one (copy through the first 1, invert after); seen_one sets after a raw 1 is processed.
REQ-016 SHIFT SHALL last exactly N cycles, then go to DONE; capture-to-out_valid latency = N+1 edges.
REQ-017 DONE: out_valid=1 and out_tc stable; out_valid & out_ready at an edge returns to IDLE; out_tc stays unchanged until the next result is written.
REQ-018 in_ready SHALL be 0 in SHIFT and DONE; in_valid is ignored outside IDLE; no back-to-back acceptance in the cycle DONE exits.
REQ-019 sign=1 with mag=0 (negative zero) SHALL yield out_tc=0.
REQ-020 mag = all ones with sign=1 SHALL yield the exact negation; no overflow is possible, given the extra MSB.
REQ-021 out_ready held high with no result pending SHALL have no effect.

Reset
REQ-022 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_tc=0, shift register, counter, and flags to 0.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse follows deassertion.
REQ-024 After reset_n rises, the first edge with in_valid=1 SHALL be accepted.

Configuration
REQ-025 Macro SM2TC_NEGZERO_FLAG_EN defined: adds output port neg_zero (1 bit), valid with out_valid, high when the operand was sign=1, mag=0; reset value 0, cleared on each capture.
REQ-026 Macro SM2TC_NEGZERO_FLAG_EN undefined: the port and its logic are absent; all other behaviour is identical.

Verification (bench with `REG_SIZE=7: M=8, N=9)
REQ-027 sign=0, mag=8'h2D -> out_valid after 10 edges, out_tc=9'h02D, busy high for exactly 9 cycles.
REQ-028 sign=1, mag=8'h2D -> out_tc=9'h1D3; sign=1, mag=8'hFF -> out_tc=9'h101.
REQ-029 sign=1, mag=8'h00 -> out_tc=9'h000; neg_zero=1 when SM2TC_NEGZERO_FLAG_EN is defined.
REQ-030 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> out_tc stable, in_ready=0, second operand not taken; then out_ready=1 -> IDLE next edge.
REQ-031 reset_n pulsed low at SHIFT cycle 4 -> all outputs take reset values asynchronously, no out_valid afterwards, and the next operand converts correctly.
REQ-032 Random 1000 operands with random out_ready stalls -> every out_tc equals the reference negation; operand count equals result count.
